// File: rtl/vmx_result_collector.sv
// Pops product rows from the eaq FIFO, requantizes each element to OUT_BITLEN with
// round-half-up and saturation, and streams one beat per row with tlast framing.
module vmx_result_collector #(
    parameter int unsigned ARRAY_SIZE     = 4,
    parameter int unsigned PRODUCT_BITLEN = 32,
    parameter int unsigned OUT_BITLEN     = 16,
    parameter int unsigned BURST_LEN      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PRODUCT_BITLEN*ARRAY_SIZE-1:0] eaq_fifo_dout,
    input  logic                                 eaq_fifo_empty,
    output logic                                 eaq_fifo_rden,
    input  logic                                 cfg_enable,
    input  logic [4:0]                           cfg_shift,
    input  logic                                 sat_clr,
    output logic [OUT_BITLEN*ARRAY_SIZE-1:0]     m_tdata,
    output logic                                 m_tvalid,
    output logic                                 m_tlast,
    input  logic                                 m_tready,
    output logic                                 sat_flag,
    output logic [15:0]                          frame_count,
    output logic                                 busy
);

    localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned ExtW = PRODUCT_BITLEN + 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
    localparam logic signed [ExtW-1:0] SatMax =
        {{(PRODUCT_BITLEN - OUT_BITLEN + 2){1'b0}}, {(OUT_BITLEN - 1){1'b1}}};
    localparam logic signed [ExtW-1:0] SatMin =
        {{(PRODUCT_BITLEN - OUT_BITLEN + 2){1'b1}}, {(OUT_BITLEN - 1){1'b0}}};

    logic [OUT_BITLEN*ARRAY_SIZE-1:0] tdata_q, tdata_d;
    logic                             tvalid_q, tlast_q, sat_q;
    logic [15:0]                      frame_q;
    logic [CntW-1:0]                  beat_q;
    logic [ARRAY_SIZE-1:0]            elem_sat;
    logic                             pop, handshake, beat_wrap;

    // Gating with rst keeps the queue untouched while the block is held in reset.
    assign pop       = ~rst & cfg_enable & ~eaq_fifo_empty & (~tvalid_q | m_tready);
    assign handshake = tvalid_q & m_tready;
    assign beat_wrap = (beat_q == LastBeat);

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_elem
        logic signed [ExtW-1:0] ext, bias, shifted;

        assign ext = {eaq_fifo_dout[i*PRODUCT_BITLEN+PRODUCT_BITLEN-1],
                      eaq_fifo_dout[i*PRODUCT_BITLEN +: PRODUCT_BITLEN]};
        // 2^(s-1) for s>0, zero for s=0; the extra bit keeps the sum from overflowing.
        assign bias    = (ExtW'(1) << cfg_shift) >> 1;
        assign shifted = (ext + bias) >>> cfg_shift;
        assign elem_sat[i] = (shifted > SatMax) | (shifted < SatMin);
        assign tdata_d[i*OUT_BITLEN +: OUT_BITLEN] =
            (shifted > SatMax) ? SatMax[OUT_BITLEN-1:0] :
            (shifted < SatMin) ? SatMin[OUT_BITLEN-1:0] : shifted[OUT_BITLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sat_q    <= 1'b0;
            frame_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (pop) begin
                tdata_q  <= tdata_d;
                tvalid_q <= 1'b1;
                tlast_q  <= beat_wrap;
                beat_q   <= beat_wrap ? '0 : beat_q + 1'b1;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
            end
            if (handshake & tlast_q) begin
                frame_q <= frame_q + 16'd1;
            end
            if (pop & (|elem_sat)) begin
                sat_q <= 1'b1;
            end else if (sat_clr) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign eaq_fifo_rden = pop;
    assign m_tdata       = tdata_q;
    assign m_tvalid      = tvalid_q;
    assign m_tlast       = tlast_q;
    assign sat_flag      = sat_q;
    assign frame_count   = frame_q;
    assign busy          = tvalid_q | (beat_q != '0);

endmodule

// File: tb/tb_vmx_result_collector.sv
// Scoreboard bench for vmx_result_collector: a FIFO model feeds rows, a reference model
// queues expected beats at pop time, and a monitor checks them on each output handshake.
module tb_vmx_result_collector;

    localparam int A = 4;
    localparam int P = 32;
    localparam int O = 16;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [P*A-1:0] dout;
    logic           empty;
    logic           rden;
    logic           en;
    logic [4:0]     shift;
    logic           clr;
    logic [O*A-1:0] tdata;
    logic           tvalid, tlast, tready;
    logic           satf;
    logic [15:0]    fcnt;
    logic           busy;

    always #5 clk = ~clk;

    vmx_result_collector #(
        .ARRAY_SIZE    (A),
        .PRODUCT_BITLEN(P),
        .OUT_BITLEN    (O),
        .BURST_LEN     (B)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .eaq_fifo_dout (dout),
        .eaq_fifo_empty(empty),
        .eaq_fifo_rden (rden),
        .cfg_enable    (en),
        .cfg_shift     (shift),
        .sat_clr       (clr),
        .m_tdata       (tdata),
        .m_tvalid      (tvalid),
        .m_tlast       (tlast),
        .m_tready      (tready),
        .sat_flag      (satf),
        .frame_count   (fcnt),
        .busy          (busy)
    );

    typedef struct {
        logic [O*A-1:0] data;
        logic           last;
    } beat_t;

    int             total = 0;
    int             bad = 0;
    beat_t          expq[$];
    logic [P*A-1:0] rows[$];
    bit             pend = 0;

    bit             vld_m = 0, last_m = 0, sat_m = 0;
    logic [15:0]    frame_m = '0;
    int             pops_m = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint requant(input longint x, input int s, output bit sat);
        longint v;
        v = x;
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        sat = 0;
        if (v > 32767) begin
            v = 32767;
            sat = 1;
        end else if (v < -32768) begin
            v = -32768;
            sat = 1;
        end
        return v;
    endfunction

    task automatic refresh();
        empty = (rows.size() == 0);
        dout  = empty ? '0 : rows[0];
    endtask

    task automatic push_row(input logic [P*A-1:0] r);
        rows.push_back(r);
        refresh();
    endtask

    function automatic logic [P*A-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] rand_elem();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($signed($urandom_range(0, 80000)) - 40000);
            2: return 32'($signed($urandom_range(0, 2000)) - 1000);
            default: begin
                case ($urandom_range(0, 2))
                    0: return 32'h7FFF_FFFF;
                    1: return 32'h8000_0000;
                    default: return 32'h0;
                endcase
            end
        endcase
    endfunction

    function automatic logic [P*A-1:0] rand_row();
        logic [P*A-1:0] r;
        for (int i = 0; i < A; i++) r[i*P +: P] = rand_elem();
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((rows.size() > 0 || tvalid) && k < 300) begin
            cyc(1);
            k++;
        end
        chk("drain_timeout", longint'(rows.size() > 0 || tvalid), 0);
    endtask

    // Reference model: compares current status, then predicts the next edge.
    always @(negedge clk) begin
        bit     exp_rden, hs, any_sat, s;
        beat_t  b;
        longint v;
        exp_rden = !rst && en && !empty && (!vld_m || tready);
        chk("rden", rden, exp_rden);
        chk("tvalid", tvalid, vld_m);
        chk("sat_flag", satf, sat_m);
        chk("frame_count", fcnt, frame_m);
        chk("busy", busy, vld_m || (pops_m % B != 0));
        if (rst) begin
            vld_m = 0;
            last_m = 0;
            sat_m = 0;
            frame_m = '0;
            pops_m = 0;
            pend = 0;
            expq.delete();
        end else begin
            hs = vld_m && tready;
            if (hs && last_m) frame_m = frame_m + 16'd1;
            if (exp_rden) begin
                any_sat = 0;
                for (int i = 0; i < A; i++) begin
                    v = requant(longint'($signed(dout[i*P +: P])), int'(shift), s);
                    b.data[i*O +: O] = v[O-1:0];
                    any_sat = any_sat | s;
                end
                b.last = ((pops_m % B) == B - 1);
                pops_m++;
                expq.push_back(b);
                vld_m = 1;
                last_m = b.last;
                pend = 1;
                if (any_sat) sat_m = 1;
                else if (clr) sat_m = 0;
            end else begin
                if (hs) vld_m = 0;
                if (clr) sat_m = 0;
            end
        end
    end

    // Monitor: every presented beat must match the scoreboard head, stalled or not.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && tvalid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %0h want none at %0t", tdata, $time);
            end else begin
                e = expq[0];
                chk("tdata", tdata, e.data);
                if (tready) begin
                    chk("tlast", tlast, e.last);
                    void'(expq.pop_front());
                end else begin
                    chk("rden_stall", rden, 0);
                end
            end
        end
    end

    // FIFO model: the head moves just after the edge at which the DUT popped it.
    always begin
        @(posedge clk);
        #1;
        if (pend) begin
            void'(rows.pop_front());
            pend = 0;
        end
        refresh();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        en = 0;
        shift = 0;
        clr = 0;
        tready = 1;
        refresh();
        cyc(2);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        rst = 0;
        en = 1;

        // Passthrough
        repeat (2) push_row(mk(32'd1, -32'sd1, 32'd32767, -32'sd32768));
        drain();
        chk("pass_sat", satf, 0);

        // Rounding and saturation
        shift = 4;
        push_row(mk(32'd24, -32'sd24, 32'h7FFF_FFFF, 32'h8000_0000));
        drain();
        chk("sat_set", satf, 1);
        cyc(3);
        chk("sat_hold", satf, 1);
        clr = 1;
        cyc(1);
        clr = 0;
        chk("sat_clr", satf, 0);

        // Framing from a clean count
        rst = 1;
        cyc(1);
        rst = 0;
        shift = 0;
        for (int i = 0; i < 10; i++) push_row(rand_row());
        drain();
        chk("frame_cnt_10", fcnt, 2);
        chk("busy_mid_frame", busy, 1);

        // Backpressure with tready 1,0,0,1
        for (int i = 0; i < 8; i++) push_row(rand_row());
        for (int k = 0; k < 40; k++) begin
            tready = (k % 4 == 0) || (k % 4 == 3);
            cyc(1);
        end
        tready = 1;
        drain();

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 2) == 0 && rows.size() < 8) push_row(rand_row());
            tready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            shift = 5'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        en = 1;
        tready = 1;
        clr = 0;
        drain();

        // Enable gating
        en = 0;
        for (int i = 0; i < 4; i++) push_row(rand_row());
        cyc(6);
        chk("en_gate_rows", rows.size(), 4);

        // Reset mid-frame with a held beat at count 2
        rst = 1;
        cyc(1);
        rst = 0;
        en = 1;
        tready = 0;
        cyc(1);
        tready = 1;
        cyc(1);
        tready = 0;
        cyc(1);
        chk("held_before_rst", tvalid, 1);
        rst = 1;
        cyc(1);
        chk("rst_mid_tvalid", tvalid, 0);
        chk("rst_mid_tdata", tdata, 0);
        chk("rst_mid_tlast", tlast, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frames", fcnt, 0);
        chk("rst_mid_rden", rden, 0);
        chk("rst_rows_kept", rows.size(), 2);
        rst = 0;
        tready = 1;
        for (int i = 0; i < 2; i++) push_row(rand_row());
        drain();
        chk("frame_after_rst", fcnt, 1);
        chk("busy_after_rst", busy, 0);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmx_result_collector.md
# vmx_result_collector

Downstream stage of the VMX execute processor. Pops packed product rows from the execute-to-AXI output queue (eaq FIFO) and requantizes each signed 32-bit product to signed 16-bit with a runtime shift, round-half-up and saturation. Packs each row into one beat of a valid/ready stream, with `m_tlast` framing every `BURST_LEN` beats. Also keeps sticky saturation status and a frame counter for the host driver.

## Interface
Parameters:
- `ARRAY_SIZE`, 4: elements per row; must match the systolic array.
- `PRODUCT_BITLEN`, 32: signed product width per element.
- `OUT_BITLEN`, 16: signed output width per element.
- `BURST_LEN`, 16: beats per frame, ≥1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `eaq_fifo_dout` in PRODUCT_BITLEN*ARRAY_SIZE: head row, first-word-fall-through; element i at `[i*PRODUCT_BITLEN +: PRODUCT_BITLEN]`.
- `eaq_fifo_empty` in 1: queue empty.
- `eaq_fifo_rden` out 1: pop; asserted only when not empty.
- `cfg_enable` in 1: permits popping.
- `cfg_shift` in 5: arithmetic right shift, 0–31.
- `sat_clr` in 1: clears `sat_flag`.
- `m_tdata` out OUT_BITLEN*ARRAY_SIZE: packed output row; element i at `[i*OUT_BITLEN +: OUT_BITLEN]`.
- `m_tvalid` out 1: beat valid.
- `m_tlast` out 1: last beat of a frame.
- `m_tready` in 1: consumer accepts.
- `sat_flag` out 1: sticky; set if any element of any popped row saturated.
- `frame_count` out 16: completed frames, wraps 0xFFFF→0.
- `busy` out 1: `m_tvalid` or beat counter ≠ 0.

## Operation
- Single output holding register (`m_tdata`/`m_tvalid`/`m_tlast`).
- Pop condition:
  - `eaq_fifo_rden = cfg_enable & ~eaq_fifo_empty & (~m_tvalid | m_tready)`.
  - Combinational from these inputs.
- On a pop, the row is transformed and loaded into the output register, and `m_tvalid` is set.
- On `m_tvalid & m_tready` with no pop, `m_tvalid` clears.
- Per-element arithmetic, with x = signed product and s = `cfg_shift` sampled in the pop cycle:
  - Extend x to PRODUCT_BITLEN+1 bits.
  - If s>0, add 2^(s-1); s=0 adds nothing.
  - Arithmetic shift right by s.
  - Saturate to [-2^(OUT_BITLEN-1), 2^(OUT_BITLEN-1)-1].
  - Saturation means the shifted value lies outside that range.
- `sat_flag`:
  - Set in the pop cycle if any element of that row saturates.
  - Cleared by `sat_clr`.
  - If set and clear occur in the same cycle, set wins.
- Beat counter, 0..BURST_LEN-1:
  - Increments on each pop.
  - The popped row gets `m_tlast`=1 when the counter equals BURST_LEN-1, and the counter wraps to 0.
  - `frame_count` increments when a beat with `m_tlast`=1 handshakes (`m_tvalid & m_tready`).
- `cfg_enable` low:
  - No new pops.
  - A held beat stays valid until accepted.
  - The beat counter is retained, so a frame resumes mid-count.
- The output register holds stable while `m_tvalid & ~m_tready`; valid/ready stream rules apply (no retraction).

## Timing
- Latency: pop at cycle N → `m_tvalid` and data at cycle N+1.
- Throughput: 1 row/cycle with `m_tready` held high and the queue non-empty.
- Back-to-back rule: handshake and pop in the same cycle → the new beat replaces the old at N+1 and `m_tvalid` stays 1.
- Reset values, while `rst`=1 and in the cycle after:
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0.
  - `sat_flag`=0, `frame_count`=0, beat counter=0, `busy`=0.
  - `eaq_fifo_rden`=0.
- Reset mid-frame drops any held beat and restarts framing at beat 0. Rows still in the queue are not touched.
- `eaq_fifo_empty`=1 never produces `eaq_fifo_rden`, regardless of other inputs.

## Test plan
- **Passthrough:** `cfg_shift`=0, rows {1,-1,32767,-32768}, `m_tready`=1.
  - `m_tdata` equals the inputs one cycle after each pop.
  - `sat_flag`=0.
- **Rounding and saturation:** `cfg_shift`=4, row {24, -24, 0x7FFFFFFF, 0x80000000}.
  - Output {2, -1, 32767, -32768}.
  - `sat_flag` goes to 1 and holds.
  - `sat_clr` pulse → 0.
- **Framing:** BURST_LEN=4, 10 rows streamed.
  - `m_tlast` on beats 4 and 8.
  - `frame_count`=2; `busy`=1 after the last beat is accepted (counter=2).
- **Backpressure:** 8 rows queued, `m_tready` toggled 1,0,0,1 repeatedly.
  - No row lost or duplicated.
  - `m_tdata` stable while stalled.
  - `eaq_fifo_rden` low during every stall cycle.
- **Enable gating and reset:**
  - `cfg_enable`=0 with the queue full → no pops.
  - Assert `rst` mid-frame (counter=2, beat held) → all outputs at reset values next cycle, and framing restarts at beat 0.
